// File: rtl/grf_bypass_if.sv
// Write-back / decode-read bundle for the general register file.
// The pipeline side drives the write and read addresses (master); the register
// file answers with read data, the write log and the commit counter (slave).
interface grf_bypass_if #(
    parameter int DATA_W    = 32,
    parameter int NREG_LOG2 = 5
);
    logic                 we;
    logic [NREG_LOG2-1:0] wa;
    logic [DATA_W-1:0]    wd;
    logic [31:0]          pc_w;
    logic [NREG_LOG2-1:0] ra1;
    logic [NREG_LOG2-1:0] ra2;
    logic [DATA_W-1:0]    rd1;
    logic [DATA_W-1:0]    rd2;
    logic                 wlog_valid;
    logic [31:0]          wlog_pc;
    logic [NREG_LOG2-1:0] wlog_addr;
    logic [DATA_W-1:0]    wlog_data;
    logic [31:0]          wr_count;

    modport master (
        output we, wa, wd, pc_w, ra1, ra2,
        input  rd1, rd2, wlog_valid, wlog_pc, wlog_addr, wlog_data, wr_count
    );

    modport slave (
        input  we, wa, wd, pc_w, ra1, ra2,
        output rd1, rd2, wlog_valid, wlog_pc, wlog_addr, wlog_data, wr_count
    );
endinterface

// File: rtl/grf_bypass.sv
// General register file at the W end of the 5-stage pipeline.
// Register 0 reads as zero and ignores writes. Two combinational read ports,
// each with an optional same-cycle W-to-D bypass. A one-cycle-late write log and
// a free-running commit counter feed the trace.

// One read port: zero register, optional bypass of the in-flight write, else storage.
module grf_bypass_rdport #(
    parameter int DATA_W    = 32,
    parameter int NREG_LOG2 = 5,
    parameter bit BYPASS    = 1'b1
) (
    input  logic [(1<<NREG_LOG2)-1:0][DATA_W-1:0] i_regs,
    input  logic                                  i_wr_live,
    input  logic [NREG_LOG2-1:0]                  i_wa,
    input  logic [DATA_W-1:0]                     i_wd,
    input  logic [NREG_LOG2-1:0]                  i_ra,
    output logic [DATA_W-1:0]                     o_rd
);
    logic w_hit;

    // The bypass only fires while out of reset, since no write can commit then.
    assign w_hit = BYPASS && i_wr_live && (i_wa == i_ra);

    // Priority: zero register, then forwarded write data, then stored value.
    always_comb begin
        o_rd = i_regs[i_ra];
        if (i_ra == '0)
            o_rd = '0;
        else if (w_hit)
            o_rd = i_wd;
    end
endmodule

module grf_bypass #(
    parameter int DATA_W    = 32,
    parameter int NREG_LOG2 = 5,
    parameter bit BYPASS    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    grf_bypass_if.slave bus
);
    localparam int NREG    = 1 << NREG_LOG2;
    localparam int NPORTS  = 2;

    logic [NREG-1:0][DATA_W-1:0]      r_regs;
    logic                             r_wlog_valid;
    logic [31:0]                      r_wlog_pc;
    logic [NREG_LOG2-1:0]             r_wlog_addr;
    logic [DATA_W-1:0]                r_wlog_data;
    logic [31:0]                      r_wr_count;

    logic                             w_commit;
    logic                             w_wr_live;
    logic [NPORTS-1:0][NREG_LOG2-1:0] w_ra;
    logic [NPORTS-1:0][DATA_W-1:0]    w_rd;

    // A write to register 0 is dropped entirely: no storage, log or count.
    assign w_commit  = bus.we && (bus.wa != '0);
    assign w_wr_live = bus.we && reset;

    // Register storage; entry 0 is never written so it stays at its reset zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_regs <= '0;
        else if (w_commit)
            r_regs[bus.wa] <= bus.wd;
    end

    // Write log: valid pulses one cycle after each commit, fields hold otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wlog_valid <= 1'b0;
            r_wlog_pc    <= '0;
            r_wlog_addr  <= '0;
            r_wlog_data  <= '0;
        end else begin
            r_wlog_valid <= w_commit;
            if (w_commit) begin
                r_wlog_pc   <= bus.pc_w;
                r_wlog_addr <= bus.wa;
                r_wlog_data <= bus.wd;
            end
        end
    end

    // Commit counter, wraps naturally at 2^32.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_wr_count <= '0;
        else if (w_commit)
            r_wr_count <= r_wr_count + 32'd1;
    end

    assign w_ra = {bus.ra2, bus.ra1};

    genvar p;
    generate
        for (p = 0; p < NPORTS; p++) begin : g_rd
            grf_bypass_rdport #(
                .DATA_W   (DATA_W),
                .NREG_LOG2(NREG_LOG2),
                .BYPASS   (BYPASS)
            ) u_rd (
                .i_regs   (r_regs),
                .i_wr_live(w_wr_live),
                .i_wa     (bus.wa),
                .i_wd     (bus.wd),
                .i_ra     (w_ra[p]),
                .o_rd     (w_rd[p])
            );
        end
    endgenerate

    assign bus.rd1        = w_rd[0];
    assign bus.rd2        = w_rd[1];
    assign bus.wlog_valid = r_wlog_valid;
    assign bus.wlog_pc    = r_wlog_pc;
    assign bus.wlog_addr  = r_wlog_addr;
    assign bus.wlog_data  = r_wlog_data;
    assign bus.wr_count   = r_wr_count;
endmodule

// File: tb/tb_grf_bypass.sv
// Bench for grf_bypass: one bypassing and one non-bypassing instance share the
// same stimulus and are compared against an array-based register file model.
module tb_grf_bypass;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  wa = '0;
    logic [31:0] wd = '0;
    logic [31:0] pc_w = '0;
    logic [4:0]  ra1 = '0;
    logic [4:0]  ra2 = '0;

    int checks = 0;
    int errors = 0;

    // reference state
    logic [31:0] mdl [32];
    logic        m_lv;
    logic [31:0] m_lp, m_ld, m_cnt;
    logic [4:0]  m_la;

    always #5 clk = ~clk;

    grf_bypass_if #(.DATA_W(32), .NREG_LOG2(5)) if_b ();
    grf_bypass_if #(.DATA_W(32), .NREG_LOG2(5)) if_n ();

    assign if_b.we = we;   assign if_n.we = we;
    assign if_b.wa = wa;   assign if_n.wa = wa;
    assign if_b.wd = wd;   assign if_n.wd = wd;
    assign if_b.pc_w = pc_w; assign if_n.pc_w = pc_w;
    assign if_b.ra1 = ra1; assign if_n.ra1 = ra1;
    assign if_b.ra2 = ra2; assign if_n.ra2 = ra2;

    grf_bypass #(.DATA_W(32), .NREG_LOG2(5), .BYPASS(1'b1)) dut_b (.clk(clk), .reset(rst_n), .bus(if_b.slave));
    grf_bypass #(.DATA_W(32), .NREG_LOG2(5), .BYPASS(1'b0)) dut_n (.clk(clk), .reset(rst_n), .bus(if_n.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic mdl_clear();
        foreach (mdl[i]) mdl[i] = 32'd0;
        m_lv = 1'b0; m_lp = '0; m_ld = '0; m_la = '0; m_cnt = '0;
    endtask

    // Architectural read: r0 is zero; a live write may be forwarded; else stored.
    function automatic logic [31:0] exp_rd(input bit byp, input logic [4:0] ra);
        if (ra == 0) return 32'd0;
        if (byp && we && rst_n && wa == ra) return wd;
        return mdl[ra];
    endfunction

    task automatic chk_reads(input string tag);
        chk({tag, ".b.rd1"}, if_b.rd1, exp_rd(1'b1, ra1));
        chk({tag, ".b.rd2"}, if_b.rd2, exp_rd(1'b1, ra2));
        chk({tag, ".n.rd1"}, if_n.rd1, exp_rd(1'b0, ra1));
        chk({tag, ".n.rd2"}, if_n.rd2, exp_rd(1'b0, ra2));
    endtask

    task automatic chk_log(input string tag);
        chk({tag, ".b.lv"},  {31'd0, if_b.wlog_valid}, {31'd0, m_lv});
        chk({tag, ".b.lp"},  if_b.wlog_pc, m_lp);
        chk({tag, ".b.la"},  {27'd0, if_b.wlog_addr}, {27'd0, m_la});
        chk({tag, ".b.ld"},  if_b.wlog_data, m_ld);
        chk({tag, ".b.cnt"}, if_b.wr_count, m_cnt);
        chk({tag, ".n.lv"},  {31'd0, if_n.wlog_valid}, {31'd0, m_lv});
        chk({tag, ".n.cnt"}, if_n.wr_count, m_cnt);
        chk({tag, ".n.ld"},  if_n.wlog_data, m_ld);
    endtask

    // One clock: drive, check reads before the edge, advance model, check log after.
    task automatic step(input string tag, input bit we_, input logic [4:0] wa_,
                        input logic [31:0] wd_, input logic [31:0] pc_,
                        input logic [4:0] r1, input logic [4:0] r2);
        we = we_; wa = wa_; wd = wd_; pc_w = pc_; ra1 = r1; ra2 = r2;
        #1;
        chk_reads(tag);
        @(posedge clk);
        if (rst_n && we_ && wa_ != 0) begin
            mdl[wa_] = wd_;
            m_cnt = m_cnt + 1;
            m_lv = 1'b1; m_lp = pc_; m_la = wa_; m_ld = wd_;
        end else begin
            m_lv = 1'b0;
        end
        if (!rst_n) mdl_clear();
        #1;
        chk_log(tag);
    endtask

    initial begin
        mdl_clear();
        @(posedge clk); #1;

        // reset held with a write pending: nothing commits, bypass suppressed
        for (int i = 0; i < 3; i++) step("rst_hold", 1'b1, 5'd5, 32'h1234, 32'h100, 5'd5, 5'd5);
        chk("rst.b.rd1_const", if_b.rd1, 32'd0);
        chk("rst.cnt_const", if_b.wr_count, 32'd0);
        rst_n = 1'b1;
        step("rst_release", 1'b1, 5'd5, 32'h1234, 32'h104, 5'd5, 5'd0);
        chk("rst.cnt_one", if_b.wr_count, 32'd1);

        // zero register write discarded
        step("zero_wr", 1'b1, 5'd0, 32'hDEADBEEF, 32'h108, 5'd0, 5'd5);
        step("zero_rd", 1'b0, 5'd0, 32'h0, 32'h10C, 5'd0, 5'd0);

        // bypass vs storage on reg 8
        step("pre8", 1'b1, 5'd8, 32'h11112222, 32'h110, 5'd0, 5'd0);
        step("byp8", 1'b1, 5'd8, 32'hCAFEF00D, 32'h114, 5'd8, 5'd8);
        step("post8", 1'b0, 5'd0, 32'h0, 32'h118, 5'd8, 5'd8);
        chk("post8.n_const", if_n.rd1, 32'hCAFEF00D);

        // log timing: commit then idle, fields hold
        step("log_w", 1'b1, 5'd31, 32'h00003008, 32'h00003000, 5'd0, 5'd0);
        chk("log.addr_const", {27'd0, if_b.wlog_addr}, 32'd31);
        step("log_idle", 1'b0, 5'd31, 32'h0, 32'h3004, 5'd31, 5'd0);
        chk("log.hold_const", if_b.wlog_data, 32'h00003008);

        // async reset mid-stream after 10 writes
        for (int i = 1; i <= 10; i++)
            step("pre_ar", 1'b1, 5'(i), 32'(i * 7 + 1), 32'(i * 4), 5'(i), 5'(i - 1));
        #2;
        rst_n = 1'b0;
        mdl_clear();
        #1;
        chk_log("async_rst");
        chk("async.cnt_const", if_b.wr_count, 32'd0);
        we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i); ra2 = 5'(31 - i);
            #0.1;
            chk_reads("async_rd");
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // back-to-back writes to regs 1..31
        for (int i = 1; i <= 31; i++)
            step("b2b", 1'b1, 5'(i), 32'(i * 4), 32'h2000 + 32'(i * 4), 5'(i), 5'(i - 1));
        chk("b2b.cnt_const", if_b.wr_count, 32'd31);
        for (int i = 0; i < 32; i++)
            step("b2b_rd", 1'b0, 5'd0, 32'h0, 32'h0, 5'(i), 5'(i));

        // randomized traffic, addresses biased toward collisions
        for (int n = 0; n < 400; n++) begin
            logic [4:0] a, r1, r2;
            a  = 5'($urandom_range(0, 31));
            r1 = ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 31));
            r2 = ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 31));
            step("rand", 1'($urandom_range(0, 1)), a, $urandom, $urandom, r1, r2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
